// File: rtl/parking_gate_ctrl.sv
// Single-lane car-park barrier controller: synchronised and debounced entry/exit IR
// sensors, a shared barrier FSM, a millisecond phase timer and a saturating occupancy count.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int DEBOUNCE_MS = 100,
  parameter int GATE_MS     = 2000,
  parameter int CLOSE_MS    = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             ir_in,
  input  logic             ir_out,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam int DB_W    = $clog2(DEBOUNCE_MS + 1);
  localparam int TMR_MAX = (GATE_MS > CLOSE_MS) ? GATE_MS : CLOSE_MS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_SAT  = DB_W'(DEBOUNCE_MS);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] GATE_T  = TMR_W'(GATE_MS);
  localparam logic [TMR_W-1:0] CLOSE_T = TMR_W'(CLOSE_MS);
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTER_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSING    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             in_s1_q, in_s2_q, out_s1_q, out_s2_q;
  logic [DB_W-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             entry_det, exit_det, full_w;

  // A low synchronised sample restarts the count, so only an unbroken high run reaches DB_SAT.
  function automatic logic [DB_W-1:0] db_next(input logic synced, input logic tick,
                                               input logic [DB_W-1:0] cnt);
    if (!synced)
      return '0;
    else if (tick && (cnt != DB_SAT))
      return cnt + DB_W'(1);
    else
      return cnt;
  endfunction

  assign in_cnt_d  = db_next(in_s2_q, tick_ms, in_cnt_q);
  assign out_cnt_d = db_next(out_s2_q, tick_ms, out_cnt_q);
  assign entry_det = (in_cnt_q == DB_SAT);
  assign exit_det  = (out_cnt_q == DB_SAT);
  assign full_w    = (occ_q == CAP);

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    case (state_q)
      IDLE: begin
        // Exit wins a tie; a blocked entry is left pending because det is a level.
        if (exit_det)
          state_d = EXIT_OPEN;
        else if (entry_det && !full_w)
          state_d = ENTER_OPEN;
      end
      ENTER_OPEN: begin
        if (!entry_det) begin
          state_d = CLOSING;
          occ_d   = full_w ? occ_q : occ_q + CNT_W'(1);
        end
      end
      EXIT_OPEN: begin
        if (!exit_det) begin
          state_d = CLOSING;
          occ_d   = (occ_q == '0) ? occ_q : occ_q - CNT_W'(1);
        end
      end
      CLOSING: begin
        if (timer_q >= CLOSE_T)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_d != state_q)
      timer_d = '0;
    else if (tick_ms && (timer_q != TMR_SAT))
      timer_d = timer_q + TMR_W'(1);
    else
      timer_d = timer_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_s1_q   <= 1'b0;
      in_s2_q   <= 1'b0;
      out_s1_q  <= 1'b0;
      out_s2_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      timer_q   <= '0;
      occ_q     <= '0;
      state_q   <= IDLE;
    end else begin
      in_s1_q   <= ir_in;
      in_s2_q   <= in_s1_q;
      out_s1_q  <= ir_out;
      out_s2_q  <= out_s1_q;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      occ_q     <= occ_d;
      state_q   <= state_d;
    end
  end

  assign gate_open = (state_q == ENTER_OPEN) || (state_q == EXIT_OPEN);
  assign alarm     = gate_open && (timer_q >= GATE_T);
  assign occupancy = occ_q;
  assign full      = full_w;
  assign empty     = (occ_q == '0);
  assign state     = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with short timing parameters; expected values
// are hand-derived cycle counts from the sensor/debounce/FSM timing.
module tb_parking_gate_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, tick_ms, ir_in, ir_out;
  logic             gate_open, full, empty, alarm;
  logic [CNT_W-1:0] occupancy;
  logic [1:0]       state;

  int n_vec = 0;
  int n_err = 0;

  parking_gate_ctrl #(
    .CAPACITY(2), .CNT_W(CNT_W), .DEBOUNCE_MS(3), .GATE_MS(10), .CLOSE_MS(4)
  ) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .ir_in(ir_in), .ir_out(ir_out),
    .gate_open(gate_open), .occupancy(occupancy), .full(full), .empty(empty),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Three quiet clocks (covers synchroniser latency after an input change), then a 1-clk tick.
  task automatic tick();
    idle_clk(3);
    tick_ms = 1'b1;
    @(negedge clk);
    tick_ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Complete one unchecked passage through the gate and return to IDLE.
  task automatic car_pass(input bit is_exit);
    if (is_exit) ir_out = 1'b1; else ir_in = 1'b1;
    ticks(3);
    idle_clk(1);
    if (is_exit) ir_out = 1'b0; else ir_in = 1'b0;
    idle_clk(4);
    ticks(4);
    idle_clk(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_ms = 1'b0; ir_in = 1'b0; ir_out = 1'b0;
    idle_clk(3);
    rst = 1'b0;
    idle_clk(1);
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL reset_gate: got %0b want 0", gate_open); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_vec++; if (alarm !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags: got alarm=%0b full=%0b want 0 0", alarm, full); end
  endtask

  task automatic test_short_pulse();
    ir_in = 1'b1;
    ticks(2);
    idle_clk(1);
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL short_gate_hi: got %0b want 0", gate_open); end
    ir_in = 1'b0;
    idle_clk(5);
    ticks(3);
    n_vec++; if (state !== 2'd0 || gate_open !== 1'b0) begin n_err++; $display("FAIL short_idle: got state=%0d gate=%0b want 0 0", state, gate_open); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL short_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_single_entry();
    ir_in = 1'b1;
    ticks(3);
    n_vec++; if (gate_open !== 1'b0) begin n_err++; $display("FAIL entry_gate_at_det: got %0b want 0", gate_open); end
    idle_clk(1);
    n_vec++; if (gate_open !== 1'b1 || state !== 2'd1) begin n_err++; $display("FAIL entry_open: got gate=%0b state=%0d want 1 1", gate_open, state); end
    ticks(3);
    n_vec++; if (gate_open !== 1'b1 || alarm !== 1'b0) begin n_err++; $display("FAIL entry_held: got gate=%0b alarm=%0b want 1 0", gate_open, alarm); end
    ir_in = 1'b0;
    idle_clk(3);
    n_vec++; if (occupancy !== 4'd0 || state !== 2'd1) begin n_err++; $display("FAIL entry_before_fall: got occ=%0d state=%0d want 0 1", occupancy, state); end
    idle_clk(1);
    n_vec++; if (occupancy !== 4'd1 || state !== 2'd3 || gate_open !== 1'b0) begin n_err++; $display("FAIL entry_close: got occ=%0d state=%0d gate=%0b want 1 3 0", occupancy, state, gate_open); end
    n_vec++; if (empty !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL entry_flags: got empty=%0b full=%0b want 0 0", empty, full); end
    ticks(3);
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL closing_3ticks: got %0d want 3", state); end
    ticks(1);
    idle_clk(1);
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL closing_done: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_open();
    ir_in = 1'b1;
    ticks(3);
    idle_clk(1);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL rmid_pre: got state=%0d want 1", state); end
    rst = 1'b1;
    idle_clk(1);
    n_vec++; if (gate_open !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL rmid_gate: got gate=%0b state=%0d want 0 0", gate_open, state); end
    n_vec++; if (occupancy !== 4'd0 || alarm !== 1'b0) begin n_err++; $display("FAIL rmid_occ: got occ=%0d alarm=%0b want 0 0", occupancy, alarm); end
    ir_in = 1'b0;
    idle_clk(4);
    rst = 1'b0;
    idle_clk(1);
  endtask

  task automatic test_full_pending();
    car_pass(1'b0);
    car_pass(1'b0);
    n_vec++; if (occupancy !== 4'd2 || full !== 1'b1) begin n_err++; $display("FAIL full_reached: got occ=%0d full=%0b want 2 1", occupancy, full); end
    ir_in = 1'b1;
    ticks(5);
    idle_clk(2);
    n_vec++; if (gate_open !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL full_refuse: got gate=%0b state=%0d want 0 0", gate_open, state); end
    ir_out = 1'b1;
    ticks(3);
    idle_clk(1);
    n_vec++; if (state !== 2'd2 || gate_open !== 1'b1) begin n_err++; $display("FAIL full_exit_open: got state=%0d gate=%0b want 2 1", state, gate_open); end
    ir_out = 1'b0;
    idle_clk(4);
    n_vec++; if (occupancy !== 4'd1 || state !== 2'd3 || full !== 1'b0) begin n_err++; $display("FAIL full_exit_done: got occ=%0d state=%0d full=%0b want 1 3 0", occupancy, state, full); end
    ticks(4);
    idle_clk(2);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL pending_served: got state=%0d want 1", state); end
    ir_in = 1'b0;
    idle_clk(4);
    n_vec++; if (occupancy !== 4'd2 || full !== 1'b1) begin n_err++; $display("FAIL pending_occ: got occ=%0d full=%0b want 2 1", occupancy, full); end
    ticks(4);
    idle_clk(1);
    car_pass(1'b1);
    n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL exit_to_one: got %0d want 1", occupancy); end
  endtask

  task automatic test_simultaneous();
    ir_in = 1'b1;
    ir_out = 1'b1;
    ticks(3);
    idle_clk(1);
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL simul_exit_first: got state=%0d want 2", state); end
    ir_out = 1'b0;
    idle_clk(4);
    n_vec++; if (occupancy !== 4'd0 || state !== 2'd3) begin n_err++; $display("FAIL simul_exit_done: got occ=%0d state=%0d want 0 3", occupancy, state); end
    ticks(4);
    idle_clk(2);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL simul_entry_next: got state=%0d want 1", state); end
    ir_in = 1'b0;
    idle_clk(4);
    n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL simul_entry_occ: got %0d want 1", occupancy); end
    ticks(4);
    idle_clk(1);
  endtask

  task automatic test_alarm_and_empty_exit();
    ir_in = 1'b1;
    ticks(3);
    idle_clk(1);
    ticks(9);
    n_vec++; if (alarm !== 1'b0) begin n_err++; $display("FAIL alarm_tick12: got %0b want 0", alarm); end
    ticks(1);
    n_vec++; if (alarm !== 1'b1) begin n_err++; $display("FAIL alarm_tick13: got %0b want 1", alarm); end
    ticks(2);
    n_vec++; if (alarm !== 1'b1 || gate_open !== 1'b1) begin n_err++; $display("FAIL alarm_tick15: got alarm=%0b gate=%0b want 1 1", alarm, gate_open); end
    ir_in = 1'b0;
    idle_clk(4);
    n_vec++; if (alarm !== 1'b0 || state !== 2'd3 || occupancy !== 4'd2) begin n_err++; $display("FAIL alarm_clear: got alarm=%0b state=%0d occ=%0d want 0 3 2", alarm, state, occupancy); end
    ticks(4);
    idle_clk(1);
    car_pass(1'b1);
    car_pass(1'b1);
    n_vec++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL drained: got occ=%0d empty=%0b want 0 1", occupancy, empty); end
    ir_out = 1'b1;
    ticks(3);
    idle_clk(1);
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL empty_exit_open: got state=%0d want 2", state); end
    ir_out = 1'b0;
    idle_clk(4);
    n_vec++; if (occupancy !== 4'd0 || empty !== 1'b1 || state !== 2'd3) begin n_err++; $display("FAIL empty_exit_sat: got occ=%0d empty=%0b state=%0d want 0 1 3", occupancy, empty, state); end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_single_entry();
    test_reset_mid_open();
    test_full_pending();
    test_simultaneous();
    test_alarm_and_empty_exit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
